mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/wait_timer.sv | 36 +++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: sequencing states, default
// parameter values and the wait-counter width helper.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_DATA   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_ERROR  = 3'd5
  } arb_state_t;

  // Bits needed to hold the values 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating memory-wait counter.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clr        - restart the count at zero (wins over en)
//   en         - count one waited cycle
//   expired    - count has reached LIMIT; it stays there until clr
module wait_timer
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT_V)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access
// and sequences the processor through one instruction at a time.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   run                 - allow new instructions to start
//   inst_addr           - PC used for fetch
//   data_addr, data_in  - load/store address and store data
//   ctrl_mem_read/write - load/store request, sampled in EXEC
//   instr, data_out     - latched instruction and load data
//   pc_enable           - one-cycle commit strobe
//   mem_req/we/addr/wdata, mem_rdata, mem_ack - memory side
//   err                 - sticky error (timeout or read+write conflict)
//   instr_count         - committed instruction count (wraps)
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no request, waiting for run
// ST_FETCH  | instruction read outstanding
// ST_EXEC   | settle cycle, decode load/store controls
// ST_DATA   | load or store outstanding
// ST_COMMIT | pc_enable pulse, count instruction
// ST_ERROR  | memory timeout, parked until reset
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ctrl_mem_read,
  input  logic              ctrl_mem_write,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] data_out,
  output logic              pc_enable,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic [31:0]       instr_count
);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  arb_state_t state, next_state;
  logic ld_fetch, ld_data, data_we;
  logic cap_instr, cap_data, set_err;
  logic timer_clr, timer_en, wait_expired;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ld_fetch   = 1'b0;
    ld_data    = 1'b0;
    data_we    = 1'b0;
    cap_instr  = 1'b0;
    cap_data   = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          next_state = ST_FETCH;
          ld_fetch   = 1'b1;
        end
      end
      ST_FETCH: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (mem_ack) begin
          next_state = ST_EXEC;
          cap_instr  = 1'b1;
        end else if (wait_expired) begin
          next_state = ST_ERROR;
          set_err    = 1'b1;
        end
      end
      ST_EXEC: begin
        // A simultaneous read+write is flagged but the write still goes out.
        if (ctrl_mem_write) begin
          next_state = ST_DATA;
          ld_data    = 1'b1;
          data_we    = 1'b1;
          set_err    = ctrl_mem_read;
        end else if (ctrl_mem_read) begin
          next_state = ST_DATA;
          ld_data    = 1'b1;
        end else begin
          next_state = ST_COMMIT;
        end
      end
      ST_DATA: begin
        if (mem_ack) begin
          next_state = ST_COMMIT;
          cap_data   = !mem_we;
        end else if (wait_expired) begin
          next_state = ST_ERROR;
          set_err    = 1'b1;
        end
      end
      ST_COMMIT: begin
        if (run) begin
          next_state = ST_FETCH;
          ld_fetch   = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ERROR: next_state = ST_ERROR;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign timer_clr = ld_fetch | ld_data;
  assign timer_en  = ((state == ST_FETCH) || (state == ST_DATA)) && !mem_ack;
  assign pc_enable = (state == ST_COMMIT);

  wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(wait_expired)
  );

  // Request fields are loaded only on entry to FETCH/DATA, so they cannot
  // move while mem_req is high.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instr       <= '0;
      data_out    <= '0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      mem_req <= (next_state == ST_FETCH) || (next_state == ST_DATA);
      if (ld_fetch) begin
        mem_addr <= inst_addr;
        mem_we   <= 1'b0;
      end else if (ld_data) begin
        mem_addr  <= data_addr;
        mem_we    <= data_we;
        mem_wdata <= data_in;
      end
      if (cap_instr) begin
        instr <= mem_rdata;
      end
      if (cap_data) begin
        data_out <= mem_rdata;
      end
      if (set_err) begin
        err <= 1'b1;
      end
      if (state == ST_COMMIT) begin
        instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory responder.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 255;
  localparam int NV = 5;

  logic          clk = 1'b0;
  logic          rst_n, run, ctrl_mem_read, ctrl_mem_write;
  logic [AW-1:0] inst_addr, data_addr, mem_addr;
  logic [DW-1:0] data_in, instr, data_out, mem_wdata, mem_rdata;
  logic          pc_enable, mem_req, mem_we, mem_ack, err;
  logic [31:0]   instr_count;
  logic          mem_ack_model, stray_ack;

  assign mem_ack = mem_ack_model | stray_ack;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .inst_addr     (inst_addr),
    .data_addr     (data_addr),
    .data_in       (data_in),
    .ctrl_mem_read (ctrl_mem_read),
    .ctrl_mem_write(ctrl_mem_write),
    .instr         (instr),
    .data_out      (data_out),
    .pc_enable     (pc_enable),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .err           (err),
    .instr_count   (instr_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory responder: ack goes high after the request has been seen for
  // more than the configured number of cycles, for one cycle.
  logic        ack_en;
  logic [31:0] cur_fword, cur_lword;
  int          cur_fdly, cur_ddly;
  int          rcnt;

  initial begin
    mem_ack_model = 1'b0;
    mem_rdata     = '0;
    rcnt          = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack_model) begin
        mem_ack_model = 1'b0;
        rcnt          = 0;
      end else if (mem_req && ack_en) begin
        rcnt++;
        if (rcnt > ((mem_addr == inst_addr && !mem_we) ? cur_fdly : cur_ddly)) begin
          mem_ack_model = 1'b1;
          mem_rdata = mem_we ? 32'hBAD0BAD0 :
                      ((mem_addr == inst_addr) ? cur_fword : cur_lword);
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Bus monitor: request-field stability and pc_enable pulse shape.
  int          pulses = 0, stab_viol = 0, double_pc = 0;
  logic        m_req = 1'b0, m_pc = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;

  always @(negedge clk) begin
    if (mem_req && m_req && (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wdata))
      stab_viol <= stab_viol + 1;
    if (pc_enable) pulses <= pulses + 1;
    if (pc_enable && m_pc) double_pc <= double_pc + 1;
    m_req   <= mem_req;
    m_pc    <= pc_enable;
    m_we    <= mem_we;
    m_addr  <= mem_addr;
    m_wdata <= mem_wdata;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] din;
    logic [31:0] fword;
    logic [31:0] lword;
    int          fdly;
    int          ddly;
    logic [31:0] exp_instr;
    logic [31:0] exp_dout;
    int          exp_nreq;
    logic        exp_we;
    int          exp_lat;
  } vec_t;

  vec_t        tv[NV];
  int          lat, nreq, pulses0, exp_cnt;
  logic        prev_req, found, d_we;
  logic [31:0] d_addr, d_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; inst_addr = '0; data_addr = '0; data_in = '0;
    ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0; stray_ack = 1'b0; ack_en = 1'b1;
    cur_fword = '0; cur_lword = '0; cur_fdly = 1; cur_ddly = 1;

    // latency = fetch wait + 2, plus data wait + 1 when a data access occurs
    tv[0] = '{rd:0, wr:0, iaddr:32'h0, daddr:32'h100, din:32'h0, fword:32'h012A4020,
              lword:32'h0, fdly:1, ddly:1, exp_instr:32'h012A4020, exp_dout:32'h0,
              exp_nreq:1, exp_we:0, exp_lat:3};
    tv[1] = '{rd:1, wr:0, iaddr:32'h4, daddr:32'h100, din:32'h0, fword:32'h8C090100,
              lword:32'hDEADBEEF, fdly:1, ddly:1, exp_instr:32'h8C090100, exp_dout:32'hDEADBEEF,
              exp_nreq:2, exp_we:0, exp_lat:5};
    tv[2] = '{rd:0, wr:1, iaddr:32'h8, daddr:32'h104, din:32'h12345678, fword:32'hAC0A0104,
              lword:32'h55555555, fdly:1, ddly:4, exp_instr:32'hAC0A0104, exp_dout:32'hDEADBEEF,
              exp_nreq:2, exp_we:1, exp_lat:8};
    tv[3] = '{rd:1, wr:0, iaddr:32'hC, daddr:32'h200, din:32'h0, fword:32'h8C0B0200,
              lword:32'hCAFEF00D, fdly:3, ddly:2, exp_instr:32'h8C0B0200, exp_dout:32'hCAFEF00D,
              exp_nreq:2, exp_we:0, exp_lat:8};
    tv[4] = '{rd:0, wr:0, iaddr:32'h10, daddr:32'h300, din:32'h0, fword:32'h00000000,
              lword:32'h0, fdly:2, ddly:1, exp_instr:32'h00000000, exp_dout:32'hCAFEF00D,
              exp_nreq:1, exp_we:0, exp_lat:4};

    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_instr", instr, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_instr_count", instr_count, 0);
    chk("rst_err", err, 0);
    chk("rst_pc_enable", pc_enable, 0);

    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_no_req", mem_req, 0);
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    chk("idle_stray_ack_req", mem_req, 0);
    chk("idle_stray_ack_instr", instr, 0);
    chk("idle_stray_ack_count", instr_count, 0);

    // Table: each vector runs one instruction with run dropped after FETCH.
    exp_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      inst_addr = tv[i].iaddr; data_addr = tv[i].daddr; data_in = tv[i].din;
      ctrl_mem_read = tv[i].rd; ctrl_mem_write = tv[i].wr;
      cur_fword = tv[i].fword; cur_lword = tv[i].lword;
      cur_fdly = tv[i].fdly; cur_ddly = tv[i].ddly;
      run = 1'b1;
      tick();
      run = 1'b0;
      chk($sformatf("v%0d_fetch_req", i), mem_req, 1);
      chk($sformatf("v%0d_fetch_we", i), mem_we, 0);
      chk($sformatf("v%0d_fetch_addr", i), mem_addr, tv[i].iaddr);
      pulses0 = pulses; nreq = 1; prev_req = 1'b1; lat = -1;
      d_we = 1'b0; d_addr = '0; d_wdata = '0;
      for (int t = 1; t <= 60 && lat < 0; t++) begin
        tick();
        if (mem_req && !prev_req) begin
          nreq++; d_we = mem_we; d_addr = mem_addr; d_wdata = mem_wdata;
        end
        prev_req = mem_req;
        if (pc_enable) begin
          lat = t;
          chk($sformatf("v%0d_instr", i), instr, tv[i].exp_instr);
          chk($sformatf("v%0d_data_out", i), data_out, tv[i].exp_dout);
        end
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tv[i].exp_lat));
      chk($sformatf("v%0d_nreq", i), 32'(nreq), 32'(tv[i].exp_nreq));
      if (tv[i].exp_nreq == 2) begin
        chk($sformatf("v%0d_data_we", i), d_we, tv[i].exp_we);
        chk($sformatf("v%0d_data_addr", i), d_addr, tv[i].daddr);
        chk($sformatf("v%0d_data_wdata", i), d_wdata, tv[i].din);
      end
      tick();
      exp_cnt++;
      chk($sformatf("v%0d_pc_off", i), pc_enable, 0);
      chk($sformatf("v%0d_count", i), instr_count, 32'(exp_cnt));
      chk($sformatf("v%0d_idle_req", i), mem_req, 0);
      chk($sformatf("v%0d_err", i), err, 0);
      chk($sformatf("v%0d_pulses", i), 32'(pulses - pulses0), 1);
    end

    // Read and write together: write wins, err set, sequencing continues.
    inst_addr = 32'h20; data_addr = 32'h300; data_in = 32'hA5A5A5A5;
    ctrl_mem_read = 1'b1; ctrl_mem_write = 1'b1;
    cur_fword = 32'h01095020; cur_fdly = 1; cur_ddly = 1;
    run = 1'b1;
    tick();
    prev_req = 1'b1; found = 1'b0; d_we = 1'b0; d_wdata = '0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (mem_req && !prev_req) begin d_we = mem_we; d_wdata = mem_wdata; end
      prev_req = mem_req;
      if (pc_enable) found = 1'b1;
    end
    chk("rw_commit_seen", found, 1);
    chk("rw_write_we", d_we, 1);
    chk("rw_write_wdata", d_wdata, 32'hA5A5A5A5);
    chk("rw_err", err, 1);
    tick();
    chk("rw_next_fetch_req", mem_req, 1);
    chk("rw_next_fetch_addr", mem_addr, 32'h20);
    chk("rw_count", instr_count, 32'(exp_cnt + 1));
    run = 1'b0; ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (pc_enable) found = 1'b1;
    end
    tick();
    chk("rw_second_commit", found, 1);
    chk("rw_count2", instr_count, 32'(exp_cnt + 2));
    chk("rw_err_sticky", err, 1);
    chk("rw_data_out_kept", data_out, 32'hCAFEF00D);

    // Reset in the middle of a slow load.
    inst_addr = 32'h24; data_addr = 32'h400; ctrl_mem_read = 1'b1;
    cur_fword = 32'h8C0C0400; cur_lword = 32'h11112222; cur_fdly = 1; cur_ddly = 10;
    run = 1'b1;
    tick();
    run = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (mem_req && mem_addr == 32'h400) found = 1'b1;
    end
    chk("rst_data_phase_seen", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rstd_mem_req", mem_req, 0);
    chk("rstd_mem_we", mem_we, 0);
    chk("rstd_mem_addr", mem_addr, 0);
    chk("rstd_mem_wdata", mem_wdata, 0);
    chk("rstd_instr", instr, 0);
    chk("rstd_data_out", data_out, 0);
    chk("rstd_count", instr_count, 0);
    chk("rstd_err", err, 0);
    chk("rstd_pc_enable", pc_enable, 0);
    stray_ack = 1'b1;
    tick();
    rst_n = 1'b1; inst_addr = 32'h40; ctrl_mem_read = 1'b0;
    cur_fword = 32'h22223333; cur_fdly = 1; run = 1'b1;
    tick();
    stray_ack = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (mem_req) found = 1'b1;
    end
    run = 1'b0;
    chk("restart_req", found, 1);
    chk("restart_addr", mem_addr, 32'h40);
    chk("restart_we", mem_we, 0);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (pc_enable) found = 1'b1;
    end
    chk("restart_commit", found, 1);
    chk("restart_instr", instr, 32'h22223333);
    chk("restart_data_out", data_out, 0);
    tick();
    chk("restart_count", instr_count, 1);
    chk("restart_err", err, 0);

    // Withheld ack: timeout into ERROR, then nothing moves.
    ack_en = 1'b0; inst_addr = 32'h80; run = 1'b1;
    tick();
    run = 1'b0;
    chk("to_req", mem_req, 1);
    repeat (254) tick();
    chk("to_err_not_yet", err, 0);
    chk("to_req_still", mem_req, 1);
    found = 1'b0;
    for (int t = 0; t < 6 && !found; t++) begin
      tick();
      if (err) found = 1'b1;
    end
    chk("to_err_set", found, 1);
    chk("to_req_dropped", mem_req, 0);
    ack_en = 1'b1; stray_ack = 1'b1; run = 1'b1; pulses0 = pulses;
    repeat (20) tick();
    stray_ack = 1'b0; run = 1'b0;
    chk("err_state_no_pc", 32'(pulses - pulses0), 0);
    chk("err_state_req", mem_req, 0);
    chk("err_state_err", err, 1);
    chk("err_state_count", instr_count, 1);

    chk("req_fields_stable", 32'(stab_viol), 0);
    chk("pc_single_cycle", 32'(double_pc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
